oht2bin_pipe: RTL

OHT2BIN_PIPE -- requirements
Module: oht2bin_pipe

---
 rtl/oht2bin_pkg.sv | 34 +++
 rtl/oht2bin_stage.sv | 98 +++++++++
 rtl/oht2bin_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/oht2bin_pkg.sv
// oht2bin_pkg -- shared definitions for the one-hot to binary pipeline.
//   oht_res_t      : final result record {bin, nz, err}.
//   oht_levels     : number of SPLIT-ary tree levels needed to cover WIDTH.
//   stage_nlvl     : tree levels assigned to pipeline stage k.
//   stage_lvl_in   : first tree level handled by pipeline stage k.
package oht2bin_pkg;

   localparam int BIN_MAX_W = 32;

   typedef struct packed {
      logic [BIN_MAX_W-1:0] bin;
      logic                 nz;
      logic                 err;
   } oht_res_t;

   function automatic int oht_levels(input int width_log, input int split_log);
      if (split_log < 1 || width_log < 1) return 1;
      return (width_log + split_log - 1) / split_log;
   endfunction

   // Levels are spread as evenly as possible; earlier stages absorb the remainder.
   function automatic int stage_nlvl(input int levels, input int stages, input int k);
      if (stages < 1) return 0;
      return (levels / stages) + ((k < (levels % stages)) ? 1 : 0);
   endfunction

   function automatic int stage_lvl_in(input int levels, input int stages, input int k);
      int rem;
      if (stages < 1) return 0;
      rem = levels % stages;
      return k * (levels / stages) + ((k < rem) ? k : rem);
   endfunction

endpackage

// File: rtl/oht2bin_stage.sv
// oht2bin_stage -- one pipeline stage of the one-hot to binary reduction tree.
// Reduces PW tree nodes through NLVL SPLIT-ary levels starting at level LVL_IN,
// then registers the result behind a valid/ready handshake.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   up_vld/up_rdy   : upstream handshake
//   nz_i/err_i/bin_i: incoming node vectors (node j bin at bin_i[j*BW +: BW])
//   dn_vld/dn_rdy   : downstream handshake
//   nz_o/err_o/bin_o: registered node vectors after this stage's levels
module oht2bin_stage
   import oht2bin_pkg::*;
#(
   parameter int SPLIT     = 2,
   parameter int SPLIT_LOG = 1,
   parameter int PW        = 32,
   parameter int BW        = 5,
   parameter int LVL_IN    = 0,
   parameter int NLVL      = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_vld,
   output logic             up_rdy,
   input  logic [PW-1:0]    nz_i,
   input  logic [PW-1:0]    err_i,
   input  logic [PW*BW-1:0] bin_i,
   output logic             dn_vld,
   input  logic             dn_rdy,
   output logic [PW-1:0]    nz_o,
   output logic [PW-1:0]    err_o,
   output logic [PW*BW-1:0] bin_o
);

   logic [PW-1:0]    nz_c, err_c;
   logic [PW*BW-1:0] bin_c;
   logic             vld_p0;
   logic [PW-1:0]    nz_p0, err_p0;
   logic [PW*BW-1:0] bin_p0;

   // Each level merges SPLIT children into one parent. A parent's bin is the
   // child slot number placed above the children's already-resolved low bits,
   // ORed over every non-empty child, so multi-hot words yield the OR of indices.
   // Parents are packed at the low node positions; unused nodes stay zero.
   always_comb begin
      logic [PW-1:0]    nz_n, err_n;
      logic [PW*BW-1:0] bin_n;
      logic             seen;
      nz_c  = nz_i;
      err_c = err_i;
      bin_c = bin_i;
      for (int l = 0; l < NLVL; l++) begin
         nz_n  = '0;
         err_n = '0;
         bin_n = '0;
         for (int j = 0; j < PW / SPLIT; j++) begin
            seen = 1'b0;
            for (int c = 0; c < SPLIT; c++) begin
               if (nz_c[j*SPLIT+c]) begin
                  if (seen) err_n[j] = 1'b1;
                  seen     = 1'b1;
                  nz_n[j]  = 1'b1;
                  bin_n[j*BW +: BW] = bin_n[j*BW +: BW] | (BW'(c) << ((LVL_IN + l) * SPLIT_LOG));
               end
               err_n[j] = err_n[j] | err_c[j*SPLIT+c];
               bin_n[j*BW +: BW] = bin_n[j*BW +: BW] | bin_c[(j*SPLIT+c)*BW +: BW];
            end
         end
         nz_c  = nz_n;
         err_c = err_n;
         bin_c = bin_n;
      end
   end

   // Stage register: loads when empty or when its current content leaves.
   assign up_rdy = !vld_p0 || dn_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         nz_p0  <= '0;
         err_p0 <= '0;
         bin_p0 <= '0;
      end else begin
         if (up_rdy) vld_p0 <= up_vld;
         if (up_vld && up_rdy) begin
            nz_p0  <= nz_c;
            err_p0 <= err_c;
            bin_p0 <= bin_c;
         end
      end
   end

   assign dn_vld = vld_p0;
   assign nz_o   = nz_p0;
   assign err_o  = err_p0;
   assign bin_o  = bin_p0;

endmodule

// File: rtl/oht2bin_pipe.sv
// oht2bin_pipe -- pipelined one-hot to binary encoder with valid/ready flow control.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_vld/in_rdy    : input handshake, in_oht = WIDTH-bit code word
//   out_vld/out_rdy  : output handshake
//   out_bin          : OR of set-bit indices (index for one-hot, 0 for zero)
//   out_nz / out_err : any bit set / two or more bits set
//   err_cnt, err_clr : saturating count of delivered error words, sync clear
module oht2bin_pipe
   import oht2bin_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int SPLIT  = 2,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_vld,
   output logic                     in_rdy,
   input  logic [WIDTH-1:0]         in_oht,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [$clog2(WIDTH)-1:0] out_bin,
   output logic                     out_nz,
   output logic                     out_err,
   output logic [CNT_W-1:0]         err_cnt,
   input  logic                     err_clr
);

   localparam int WIDTH_LOG = $clog2(WIDTH);
   localparam int SPLIT_LOG = $clog2(SPLIT);
   localparam int LEVELS    = oht_levels(WIDTH_LOG, SPLIT_LOG);
   localparam int PW        = 1 << (LEVELS * SPLIT_LOG);
   localparam int BW        = LEVELS * SPLIT_LOG;

   if (WIDTH < 2) begin : g_bad_width
      $error("oht2bin_pipe: WIDTH must be >= 2");
   end
   if (SPLIT < 2 || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
      $error("oht2bin_pipe: SPLIT must be a power of 2 and >= 2");
   end
   if (STAGES < 1 || STAGES > LEVELS) begin : g_bad_stages
      $error("oht2bin_pipe: STAGES must be in 1..LEVELS");
   end

   logic [STAGES:0]  vld_s, rdy_s;
   logic [PW-1:0]    nz_s  [STAGES+1];
   logic [PW-1:0]    err_s [STAGES+1];
   logic [PW*BW-1:0] bin_s [STAGES+1];
   oht_res_t         res;

   // Leaves: zero-padded input bits, no error, no resolved index bits yet.
   assign vld_s[0]      = in_vld;
   assign nz_s[0]       = PW'(in_oht);
   assign err_s[0]      = '0;
   assign bin_s[0]      = '0;
   assign rdy_s[STAGES] = out_rdy;
   assign in_rdy        = rst_n && rdy_s[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      oht2bin_stage #(
         .SPLIT     (SPLIT),
         .SPLIT_LOG (SPLIT_LOG),
         .PW        (PW),
         .BW        (BW),
         .LVL_IN    (stage_lvl_in(LEVELS, STAGES, k)),
         .NLVL      (stage_nlvl(LEVELS, STAGES, k))
      ) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .up_vld (vld_s[k]),
         .up_rdy (rdy_s[k]),
         .nz_i   (nz_s[k]),
         .err_i  (err_s[k]),
         .bin_i  (bin_s[k]),
         .dn_vld (vld_s[k+1]),
         .dn_rdy (rdy_s[k+1]),
         .nz_o   (nz_s[k+1]),
         .err_o  (err_s[k+1]),
         .bin_o  (bin_s[k+1])
      );
   end

   // After the last level only root node 0 carries the result.
   always_comb begin
      res     = '0;
      res.bin = BIN_MAX_W'(bin_s[STAGES][BW-1:0]);
      res.nz  = nz_s[STAGES][0];
      res.err = err_s[STAGES][0];
   end

   assign out_vld = vld_s[STAGES];
   assign out_bin = res.bin[WIDTH_LOG-1:0];
   assign out_nz  = res.nz;
   assign out_err = res.err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if (out_vld && out_rdy && out_err && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule
